// File: rtl/note_event_recorder.sv
// -----------------------------------------------------------------------------
// note_event_recorder
//
// Captures live note events and packs them into {note_on, note, delay} message
// words for a RAM write port. The word format matches what the note-event
// player reads back, so word k holds event k together with the number of
// completed ticks until event k+1 (or until stop). A 16-bit delay field that
// would overflow is split into continuation words that repeat the same note
// state.
//
// Optional feature: define NOTE_REC_ROUND_EN to round the written delay to
// the nearest tick instead of truncating it. Continuation (saturation) words
// always carry the maximum delay.
//
// Ports:
//   clk         system clock, rising edge (10 MHz audio domain)
//   reset_n     asynchronous active-low reset
//   start       pulse, begins a new recording (IDLE or DONE only)
//   stop        pulse, ends a recording (ARMED or RUN only)
//   ev_valid    event offered
//   ev_note_on  1 = note on, 0 = note off / rest
//   ev_note     note number
//   ev_ready    event accepted when ev_valid && ev_ready
//   wr_en       RAM write strobe, one cycle per word
//   wr_addr     RAM write address (holds the last written address)
//   wr_data     {note_on, note, delay}, note_on at MSB (holds last word)
//   recording   high in ARMED and RUN
//   done        high in DONE
//   msg_count   words written in the current recording
//   overflow    sticky, a required write was dropped because RAM was full
//   dbg_state   current FSM state for observation
//
// Handshake: an event transfers on a rising clk edge where ev_valid and
// ev_ready are both high. ev_ready is combinational and is low whenever stop
// is high, so stop always wins over a simultaneous event.
// -----------------------------------------------------------------------------
module note_event_recorder #(
    parameter int NOTE_BITS  = 7,
    parameter int DELAY_BITS = 16,
    parameter int ADDR_BITS  = 10,
    parameter int TICK_DIV   = 10000
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              ev_valid,
    input  logic                              ev_note_on,
    input  logic [NOTE_BITS-1:0]              ev_note,
    output logic                              ev_ready,
    output logic                              wr_en,
    output logic [ADDR_BITS-1:0]              wr_addr,
    output logic [NOTE_BITS+DELAY_BITS:0]     wr_data,
    output logic                              recording,
    output logic                              done,
    output logic [ADDR_BITS:0]                msg_count,
    output logic                              overflow,
    output logic [2:0]                        dbg_state
);

    localparam int PRE_BITS  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PEND_BITS = 1 + NOTE_BITS;
    localparam int WORD_BITS = PEND_BITS + DELAY_BITS;
    localparam int CNT_BITS  = ADDR_BITS + 1;

    localparam logic [PRE_BITS-1:0]   PRE_LAST  = PRE_BITS'(TICK_DIV - 1);
    localparam logic [DELAY_BITS-1:0] TICKS_MAX = {DELAY_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0]   RAM_FULL  = {1'b1, {ADDR_BITS{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [PEND_BITS-1:0]   pend_q, pend_d;
    logic [PRE_BITS-1:0]    pre_q, pre_d;
    logic [DELAY_BITS-1:0]  ticks_q, ticks_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [WORD_BITS-1:0]   wr_data_q, wr_data_d;
    logic [CNT_BITS-1:0]    msg_count_q, msg_count_d;
    logic                   overflow_q, overflow_d;

    logic                   accept;
    logic                   pre_wrap;
    logic                   ram_full;
    logic                   need_wr;
    logic [DELAY_BITS-1:0]  ticks_inc;
    logic [DELAY_BITS-1:0]  ev_delay;
    logic [WORD_BITS-1:0]   wr_word;

    assign ev_ready  = ((state_q == S_ARMED) || (state_q == S_RUN)) && !stop;
    assign accept    = ev_valid && ev_ready;
    assign pre_wrap  = (pre_q == PRE_LAST);
    assign ram_full  = (msg_count_q == RAM_FULL);
    assign ticks_inc = (ticks_q == TICKS_MAX) ? ticks_q : ticks_q + DELAY_BITS'(1);

`ifdef NOTE_REC_ROUND_EN
    localparam logic [PRE_BITS-1:0] PRE_HALF = PRE_BITS'(TICK_DIV / 2);
    // Past the half-tick point the event is closer to the next tick boundary.
    assign ev_delay = ((pre_q >= PRE_HALF) && (ticks_q != TICKS_MAX)) ?
                      ticks_q + DELAY_BITS'(1) : ticks_q;
`else
    assign ev_delay = ticks_q;
`endif

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pre_d       = pre_q;
        ticks_d     = ticks_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        msg_count_d = msg_count_q;
        overflow_d  = overflow_q;
        need_wr     = 1'b0;
        wr_word     = {pend_q, ev_delay};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_ARMED;
                    msg_count_d = '0;
                    wr_addr_d   = '0;
                    overflow_d  = 1'b0;
                end
            end

            S_ARMED: begin
                // Time before the first event is not part of the recording.
                if (stop) begin
                    state_d = S_DONE;
                end else if (accept) begin
                    pend_d  = {ev_note_on, ev_note};
                    pre_d   = '0;
                    ticks_d = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                pre_d   = pre_wrap ? '0 : pre_q + PRE_BITS'(1);
                ticks_d = pre_wrap ? ticks_inc : ticks_q;

                if (stop) begin
                    need_wr = 1'b1;
                    state_d = S_FLUSH;
                end else if (accept) begin
                    need_wr = 1'b1;
                    pend_d  = {ev_note_on, ev_note};
                    pre_d   = '0;
                    ticks_d = '0;
                end else if (pre_wrap && (ticks_q == TICKS_MAX)) begin
                    // Delay field exhausted: emit a continuation word that keeps
                    // the same note state, then start counting afresh.
                    need_wr = 1'b1;
                    wr_word = {pend_q, TICKS_MAX};
                    pre_d   = '0;
                    ticks_d = '0;
                end

                if (need_wr) begin
                    if (ram_full) begin
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        wr_en_d     = 1'b1;
                        wr_data_d   = wr_word;
                        wr_addr_d   = msg_count_q[ADDR_BITS-1:0];
                        msg_count_d = msg_count_q + CNT_BITS'(1);
                    end
                end
            end

            // The flush word is on the write port during this state.
            S_FLUSH: state_d = S_DONE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            pre_q       <= '0;
            ticks_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            msg_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pre_q       <= pre_d;
            ticks_q     <= ticks_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            msg_count_q <= msg_count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign msg_count = msg_count_q;
    assign overflow  = overflow_q;
    assign recording = (state_q == S_ARMED) || (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_note_event_recorder.sv
module tb_note_event_recorder;
  localparam int NB     = 7;
  localparam int DB     = 4;
  localparam int AB     = 3;
  localparam int TD     = 4;
  localparam int W      = 1 + NB + DB;
  localparam int M      = (1 << DB) - 1;
  localparam int DEPTH  = 1 << AB;
  localparam int SAT_EL = (M + 1) * TD - 1;

`ifdef NOTE_REC_ROUND_EN
  localparam int ROUND = 1;
`else
  localparam int ROUND = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic ev_valid = 1'b0;
  logic ev_note_on = 1'b0;
  logic [NB-1:0] ev_note = '0;
  logic ev_ready, wr_en, recording, done, overflow;
  logic [AB-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic [AB:0] msg_count;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  note_event_recorder #(
    .NOTE_BITS(NB), .DELAY_BITS(DB), .ADDR_BITS(AB), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .ev_valid(ev_valid), .ev_note_on(ev_note_on), .ev_note(ev_note),
    .ev_ready(ev_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .recording(recording), .done(done), .msg_count(msg_count),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A recording is a list of segments; each segment starts on the cycle an
  // event (or continuation) is taken, and its delay is the number of whole
  // ticks elapsed before the next write.
  typedef enum int {M_IDLE, M_ARMED, M_RUN, M_FLUSH, M_DONE} mmode_t;

  mmode_t m_mode;
  logic [NB:0] m_pend;
  int m_seg, m_count, cyc;
  bit m_over, m_wr_en;
  logic [AB-1:0] m_addr;
  logic [W-1:0] m_data;
  logic [AB+W-1:0] exp_q[$];
  logic [AB+W-1:0] wr_log[$];

  function automatic int rec_delay(input int el);
    int d;
    d = el / TD;
    if (d > M) d = M;
    if (ROUND != 0 && (el % TD) >= TD / 2 && d < M) d++;
    return d;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_IDLE; m_pend = '0; m_seg = 0; m_count = 0;
      m_over = 0; m_wr_en = 0; m_addr = '0; m_data = '0;
      exp_q.delete();
    end else begin : model_step
      bit wr;
      int el;
      logic [W-1:0] word;
      wr = 0; word = '0; m_wr_en = 0;
      el = cyc - m_seg - 1;
      case (m_mode)
        M_IDLE, M_DONE: if (start) begin
          m_mode = M_ARMED; m_count = 0; m_addr = '0; m_over = 0;
        end
        M_ARMED: begin
          if (stop) m_mode = M_DONE;
          else if (ev_valid) begin
            m_pend = {ev_note_on, ev_note}; m_seg = cyc; m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (stop) begin
            word = {m_pend, DB'(rec_delay(el))}; wr = 1; m_mode = M_FLUSH;
          end else if (ev_valid) begin
            word = {m_pend, DB'(rec_delay(el))}; wr = 1;
            m_pend = {ev_note_on, ev_note}; m_seg = cyc;
          end else if (el == SAT_EL) begin
            word = {m_pend, DB'(M)}; wr = 1; m_seg = cyc;
          end
          if (wr) begin
            if (m_count == DEPTH) begin
              m_over = 1; m_mode = M_DONE;
            end else begin
              m_wr_en = 1; m_addr = AB'(m_count); m_data = word;
              exp_q.push_back({m_addr, word});
              m_count++;
            end
          end
        end
        M_FLUSH: m_mode = M_DONE;
        default: ;
      endcase
      cyc++;
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("ev_ready", ev_ready, ((m_mode == M_ARMED || m_mode == M_RUN) && !stop));
      chk("recording", recording, (m_mode == M_ARMED || m_mode == M_RUN));
      chk("done", done, (m_mode == M_DONE));
      chk("overflow", overflow, m_over);
      chk("msg_count", msg_count, m_count);
      chk("wr_en", wr_en, m_wr_en);
      if (wr_en) begin
        wr_log.push_back({wr_addr, wr_data});
        if (exp_q.size() != 0) chk("write_word", {wr_addr, wr_data}, exp_q.pop_front());
      end else begin
        chk("wr_addr_hold", wr_addr, m_addr);
        chk("wr_data_hold", wr_data, m_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic pulse_stop();
    stop = 1; step(); stop = 0;
  endtask

  task automatic send_ev(input bit on, input int note);
    ev_valid = 1; ev_note_on = on; ev_note = NB'(note);
    step();
    ev_valid = 0;
  endtask

  function automatic logic [AB+W-1:0] ent(input int a, input bit on, input int note, input int d);
    return {AB'(a), on, NB'(note), DB'(d)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int base;
    int div_tab[5];
    div_tab[0] = 1; div_tab[1] = 3; div_tab[2] = 8; div_tab[3] = 40; div_tab[4] = 120;

    step(3);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_recording", recording, 0);
    chk("rst_msg_count", msg_count, 0);
    chk("rst_wr_data", wr_data, 0);
    reset_n = 1;
    step();

    // Two events 22 cycles apart, then stop 8 idle cycles after the second.
    base = wr_log.size();
    pulse_start();
    step(3);
    send_ev(1, 60);
    step(22);
    send_ev(0, 60);
    step(8);
    chk("t1_count_after_ev", msg_count, 1);
    chk("t1_log1", wr_log.size() - base, 1);
    if (wr_log.size() > base) chk("t1_word0", wr_log[base], ent(0, 1, 60, 5 + ROUND));
    pulse_stop();
    step(2);
    chk("t1_log2", wr_log.size() - base, 2);
    if (wr_log.size() > base + 1) chk("t1_word1", wr_log[base+1], ent(1, 0, 60, 2));
    chk("t1_done", done, 1);
    chk("t1_msg_count", msg_count, 2);
    chk("t1_overflow", overflow, 0);

    // Long silence produces a continuation word carrying the max delay.
    base = wr_log.size();
    pulse_start();
    step(2);
    send_ev(1, 64);
    step(70);
    send_ev(0, 64);
    step(3);
    pulse_stop();
    step(2);
    chk("t2_log", wr_log.size() - base, 3);
    if (wr_log.size() > base + 2) begin
      chk("t2_cont", wr_log[base], ent(0, 1, 64, M));
      chk("t2_rest", wr_log[base+1], ent(1, 1, 64, 1 + ROUND));
      chk("t2_flush", wr_log[base+2], ent(2, 0, 64, 0 + ROUND));
    end

    // Stop while armed: nothing written.
    base = wr_log.size();
    pulse_start();
    step(1);
    pulse_stop();
    step(1);
    chk("t3_done", done, 1);
    chk("t3_msg_count", msg_count, 0);
    chk("t3_log", wr_log.size() - base, 0);

    // Ten events into an eight-word RAM: the ninth write is dropped.
    base = wr_log.size();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_ev(i[0], 40 + i);
      step(2);
    end
    pulse_stop();
    step(2);
    chk("t4_log", wr_log.size() - base, DEPTH);
    if (wr_log.size() == base + DEPTH) chk("t4_last", wr_log[base+DEPTH-1], ent(7, 1, 47, 0 + ROUND));
    chk("t4_overflow", overflow, 1);
    chk("t4_done", done, 1);
    chk("t4_msg_count", msg_count, DEPTH);

    // Event and stop together: stop wins, flush word goes out, then reset mid-write.
    pulse_start();
    step(1);
    send_ev(1, 70);
    step(5);
    ev_valid = 1; ev_note_on = 0; ev_note = 7'd71; stop = 1;
    #1;
    chk("t5_ready_low", ev_ready, 0);
    step();
    ev_valid = 0; stop = 0;
    chk("t5_flush_wr_en", wr_en, 1);
    chk("t5_flush_word", {wr_addr, wr_data}, ent(0, 1, 70, 1));
    reset_n = 0;
    #1;
    chk("t5_rst_wr_en", wr_en, 0);
    chk("t5_rst_addr_data", {wr_addr, wr_data}, 0);
    chk("t5_rst_msg_count", msg_count, 0);
    chk("t5_rst_flags", {recording, done, overflow, ev_ready}, 0);
    step(2);
    reset_n = 1;
    step();

    // Random traffic with varying event density.
    for (int blk = 0; blk < 12; blk++) begin
      int ev_div;
      ev_div = div_tab[$urandom_range(0, 4)];
      repeat (400) begin
        start = ($urandom_range(0, 59) == 0);
        stop = ($urandom_range(0, 199) == 0);
        ev_valid = ($urandom_range(0, ev_div - 1) == 0);
        ev_note_on = 1'($urandom_range(0, 1));
        ev_note = NB'($urandom_range(0, 127));
        if ($urandom_range(0, 1499) == 0) begin
          reset_n = 0;
          step();
          reset_n = 1;
        end
        step();
      end
    end
    start = 0; stop = 0; ev_valid = 0;
    step(5);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
